// File: rtl/ram_seq_pkg.sv
// rtl/ram_seq_pkg.sv - shared states, pending-slot codes and fixed write targets for the RAM write sequencer
package ram_seq_pkg;

   typedef enum logic [1:0] {IDLE, WRITE, CLEAR, DONE} state_t;
   typedef enum logic [1:0] {NONE, PEND_A, PEND_B} pend_t;

   localparam int BTN_A   = 0;
   localparam int BTN_B   = 1;
   localparam int BTN_CLR = 2;

   localparam int ADDR_A = 6;
   localparam int DATA_A = 9;
   localparam int ADDR_B = 0;
   localparam int DATA_B = 8;

   // A outranks B when both pulse in the same cycle
   function automatic pend_t pend_capture(input logic a, input logic b);
      if (a)
         return PEND_A;
      else if (b)
         return PEND_B;
      else
         return NONE;
   endfunction

endpackage

// File: rtl/ram_write_sequencer_if.sv
// rtl/ram_write_sequencer_if.sv - button inputs, RAM write port and status bundle
interface ram_write_sequencer_if #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 8
);
   logic [2:0]        btn;
   logic              we;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] wdata;
   logic              busy;
   logic              done;

   modport master (input btn, output we, addr, wdata, busy, done);
   modport slave  (output btn, input we, addr, wdata, busy, done);
endinterface

// File: rtl/btn_press_detect.sv
// rtl/btn_press_detect.sv - one button: synchronizer, optional debounce (DEBOUNCE_EN), registered press pulse
module btn_press_detect #(
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_btn,
   output logic o_press
);

   // Configurations below two stages or a zero-length filter are not meaningful
   if (SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 1) begin : g_bad_cfg
      $error("btn_press_detect: SYNC_STAGES must be >= 2 and DEBOUNCE_CYCLES >= 1");
   end

   logic [SYNC_STAGES-1:0] r_sync;
   logic                   w_level;
   logic                   r_prev;
   logic                   r_press;

   // Synchronizer chain, preset to the released level so reset release is not a press
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)
         r_sync <= '1;
      else
         r_sync <= {r_sync[SYNC_STAGES-2:0], i_btn};
   end

`ifdef DEBOUNCE_EN
   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

   logic [CNT_W-1:0] r_cnt;
   logic             r_filt;

   // Filtered level only follows a new level that has been stable for DEBOUNCE_CYCLES samples
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_cnt  <= '0;
         r_filt <= 1'b1;
      end else if (r_sync[SYNC_STAGES-1] == r_filt) begin
         r_cnt <= '0;
      end else if (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
         r_filt <= r_sync[SYNC_STAGES-1];
         r_cnt  <= '0;
      end else begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign w_level = r_filt;
`else
   assign w_level = r_sync[SYNC_STAGES-1];
`endif

   // Falling edge of the (filtered) level becomes a one-cycle registered press pulse
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_prev  <= 1'b1;
         r_press <= 1'b0;
      end else begin
         r_prev  <= w_level;
         r_press <= r_prev & ~w_level;
      end
   end

   assign o_press = r_press;

endmodule

// File: rtl/ram_write_sequencer.sv
// rtl/ram_write_sequencer.sv - arbitrates button writes and clear sweep onto the RAM write port (DEBOUNCE_EN selects debounce)
module ram_write_sequencer #(
   parameter int ADDR_W          = 8,
   parameter int DATA_W          = 8,
   parameter int DEPTH           = 256,
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 16
) (
   input logic                   clk,
   input logic                   rst_n,
   ram_write_sequencer_if.master bus
);
   import ram_seq_pkg::*;

   // The sweep must fit inside the address space
   if (DEPTH < 1 || DEPTH > 2**ADDR_W) begin : g_bad_depth
      $error("ram_write_sequencer: DEPTH must be in 1..2**ADDR_W");
   end

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

   logic [2:0]        w_press;
   logic              w_a;
   logic              w_b;
   logic              w_clr;
   pend_t             w_pend_busy;

   state_t            r_state;
   pend_t             r_pend;
   logic              r_we;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_wdata;
   logic              r_busy;
   logic              r_done;

   for (genvar g = 0; g < 3; g++) begin : g_btn
      btn_press_detect #(
         .SYNC_STAGES     (SYNC_STAGES),
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
      ) u_det (
         .i_clk   (clk),
         .i_rst_n (rst_n),
         .i_btn   (bus.btn[g]),
         .o_press (w_press[g])
      );
   end

   assign w_a   = w_press[BTN_A];
   assign w_b   = w_press[BTN_B];
   assign w_clr = w_press[BTN_CLR];

   // While the port is occupied only an empty slot takes a new A/B press
   always_comb begin
      w_pend_busy = r_pend;
      if (r_pend == NONE)
         w_pend_busy = pend_capture(w_a, w_b);
   end

   // Main sequencer: state, pending slot and all registered port outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_pend  <= NONE;
         r_we    <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (r_pend != NONE) begin
                  r_state <= WRITE;
                  r_we    <= 1'b1;
                  r_busy  <= 1'b1;
                  r_addr  <= (r_pend == PEND_A) ? ADDR_W'(ADDR_A) : ADDR_W'(ADDR_B);
                  r_wdata <= (r_pend == PEND_A) ? DATA_W'(DATA_A) : DATA_W'(DATA_B);
                  // the slot frees now, so a same-cycle press refills it as if busy
                  r_pend  <= pend_capture(w_a, w_b);
               end else if (w_clr) begin
                  r_state <= CLEAR;
                  r_we    <= 1'b1;
                  r_busy  <= 1'b1;
                  r_addr  <= '0;
                  r_wdata <= '0;
               end else if (w_a) begin
                  r_state <= WRITE;
                  r_we    <= 1'b1;
                  r_busy  <= 1'b1;
                  r_addr  <= ADDR_W'(ADDR_A);
                  r_wdata <= DATA_W'(DATA_A);
               end else if (w_b) begin
                  r_state <= WRITE;
                  r_we    <= 1'b1;
                  r_busy  <= 1'b1;
                  r_addr  <= ADDR_W'(ADDR_B);
                  r_wdata <= DATA_W'(DATA_B);
               end
            end
            WRITE: begin
               r_state <= DONE;
               r_we    <= 1'b0;
               r_busy  <= 1'b0;
               r_done  <= 1'b1;
               r_pend  <= w_pend_busy;
            end
            CLEAR: begin
               r_pend <= w_pend_busy;
               if (r_addr == LAST_ADDR) begin
                  r_state <= DONE;
                  r_we    <= 1'b0;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
               end else begin
                  r_addr <= r_addr + 1'b1;
               end
            end
            DONE: begin
               r_state <= IDLE;
               r_done  <= 1'b0;
               r_pend  <= w_pend_busy;
            end
         endcase
      end
   end

   assign bus.we    = r_we;
   assign bus.addr  = r_addr;
   assign bus.wdata = r_wdata;
   assign bus.busy  = r_busy;
   assign bus.done  = r_done;

endmodule

// File: tb/tb_ram_write_sequencer.sv
// tb/tb_ram_write_sequencer.sv - scoreboard bench for ram_write_sequencer with DEPTH=16
module tb_ram_write_sequencer;

   localparam int ADDR_W = 8;
   localparam int DATA_W = 8;
   localparam int DEPTH  = 16;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   int n_checks = 0;
   int n_pass   = 0;
   int n_writes = 0;

   logic [15:0] exp_q[$];

   ram_write_sequencer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   ram_write_sequencer #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1);
   end

   // Advance to the next falling edge; every observed write is popped against the scoreboard
   task automatic cyc();
      logic [15:0] e;
      @(negedge clk);
      if (rst_n && bus.we) begin
         n_writes++;
         n_checks++;
         if (exp_q.size() == 0) begin
            $display("FAIL sb_unexpected: got write addr=%0d wdata=%0d, required no write", bus.addr, bus.wdata);
         end else begin
            e = exp_q.pop_front();
            if ({bus.addr, bus.wdata} !== e || bus.busy !== 1'b1)
               $display("FAIL sb_write: got addr=%0d wdata=%0d busy=%b, required addr=%0d wdata=%0d busy=1",
                        bus.addr, bus.wdata, bus.busy, e[15:8], e[7:0]);
            else
               n_pass++;
         end
      end
   endtask

   task automatic test_reset();
      int w0;
      bus.btn = 3'b111;
      rst_n   = 1'b0;
      repeat (3) cyc();
      n_checks++;
      if ({bus.we, bus.addr, bus.wdata, bus.busy, bus.done} !== '0)
         $display("FAIL reset_outputs: got we=%b addr=%0d wdata=%0d busy=%b done=%b, required all 0",
                  bus.we, bus.addr, bus.wdata, bus.busy, bus.done);
      else
         n_pass++;
      rst_n = 1'b1;
      w0 = n_writes;
      repeat (20) cyc();
      n_checks++;
      if (n_writes - w0 !== 0 || {bus.we, bus.busy, bus.done} !== 3'b000)
         $display("FAIL reset_release: got %0d writes we=%b busy=%b done=%b, required 0 writes and idle",
                  n_writes - w0, bus.we, bus.busy, bus.done);
      else
         n_pass++;
   endtask

   task automatic test_write_a();
      int w0;
      logic [4:0] we_seq;
      logic [4:0] done_seq;
      w0 = n_writes;
      exp_q.push_back({8'd6, 8'd9});
      bus.btn = 3'b110;
      for (int k = 0; k < 5; k++) begin
         cyc();
         we_seq[k]   = bus.we;
         done_seq[k] = bus.done;
      end
      n_checks++;
      if (we_seq !== 5'b01000)
         $display("FAIL write_a_latency: got we per edge (edge5..1)=%b, required 01000", we_seq);
      else
         n_pass++;
      n_checks++;
      if (done_seq !== 5'b10000)
         $display("FAIL write_a_done: got done per edge (edge5..1)=%b, required 10000", done_seq);
      else
         n_pass++;
      repeat (5) cyc();
      bus.btn = 3'b111;
      repeat (6) cyc();
      n_checks++;
      if (n_writes - w0 !== 1 || exp_q.size() !== 0)
         $display("FAIL write_a_count: got %0d writes, %0d unserved, required 1 and 0", n_writes - w0, exp_q.size());
      else
         n_pass++;
   endtask

   task automatic test_write_b();
      int w0;
      w0 = n_writes;
      exp_q.push_back({8'd0, 8'd8});
      bus.btn = 3'b101;
      repeat (50) cyc();
      bus.btn = 3'b111;
      repeat (6) cyc();
      n_checks++;
      if (n_writes - w0 !== 1 || exp_q.size() !== 0)
         $display("FAIL write_b_hold: got %0d writes, %0d unserved, required 1 and 0", n_writes - w0, exp_q.size());
      else
         n_pass++;
      w0 = n_writes;
      exp_q.push_back({8'd0, 8'd8});
      bus.btn = 3'b101;
      repeat (8) cyc();
      bus.btn = 3'b111;
      repeat (6) cyc();
      n_checks++;
      if (n_writes - w0 !== 1 || exp_q.size() !== 0)
         $display("FAIL write_b_repress: got %0d writes, %0d unserved, required 1 and 0", n_writes - w0, exp_q.size());
      else
         n_pass++;
   endtask

   task automatic test_clear();
      int  run;
      logic seen;
      for (int i = 0; i < DEPTH; i++) exp_q.push_back({8'(i), 8'd0});
      bus.btn = 3'b011;
      repeat (3) cyc();
      bus.btn = 3'b111;
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         cyc();
         seen = bus.we;
      end
      n_checks++;
      if (!seen) begin
         $display("FAIL clear_start: got no we within 20 cycles, required clear sweep");
      end else begin
         n_pass++;
         run = 1;
         for (int i = 0; i < 40; i++) begin
            cyc();
            if (!bus.we) break;
            run++;
         end
         n_checks++;
         if (run !== DEPTH)
            $display("FAIL clear_length: got %0d consecutive we cycles, required %0d", run, DEPTH);
         else
            n_pass++;
         n_checks++;
         if (bus.done !== 1'b1 || bus.busy !== 1'b0)
            $display("FAIL clear_done: got done=%b busy=%b after sweep, required done=1 busy=0", bus.done, bus.busy);
         else
            n_pass++;
      end
      repeat (4) cyc();
   endtask

   task automatic test_pending();
      int   w0;
      logic seen;
      w0 = n_writes;
      for (int i = 0; i < DEPTH; i++) exp_q.push_back({8'(i), 8'd0});
      exp_q.push_back({8'd6, 8'd9});
      bus.btn = 3'b011;
      repeat (3) cyc();
      bus.btn = 3'b111;
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         cyc();
         seen = bus.we;
      end
      bus.btn = 3'b110;
      repeat (2) cyc();
      bus.btn = 3'b111;
      repeat (2) cyc();
      bus.btn = 3'b101;
      repeat (2) cyc();
      bus.btn = 3'b111;
      repeat (40) cyc();
      n_checks++;
      if (n_writes - w0 !== DEPTH + 1 || exp_q.size() !== 0)
         $display("FAIL pending_a: got %0d writes, %0d unserved, required %0d and 0",
                  n_writes - w0, exp_q.size(), DEPTH + 1);
      else
         n_pass++;
   endtask

   task automatic test_simultaneous();
      int w0;
      w0 = n_writes;
      for (int i = 0; i < DEPTH; i++) exp_q.push_back({8'(i), 8'd0});
      bus.btn = 3'b010;
      repeat (3) cyc();
      bus.btn = 3'b111;
      repeat (40) cyc();
      n_checks++;
      if (n_writes - w0 !== DEPTH || exp_q.size() !== 0)
         $display("FAIL clear_beats_a: got %0d writes, %0d unserved, required %0d and 0",
                  n_writes - w0, exp_q.size(), DEPTH);
      else
         n_pass++;
   endtask

   task automatic test_reset_mid_clear();
      int   w0;
      logic hit;
      w0 = n_writes;
      for (int i = 0; i <= 5; i++) exp_q.push_back({8'(i), 8'd0});
      bus.btn = 3'b011;
      repeat (3) cyc();
      bus.btn = 3'b111;
      hit = 1'b0;
      for (int i = 0; i < 30 && !hit; i++) begin
         cyc();
         hit = bus.we && (bus.addr == 8'd5);
      end
      n_checks++;
      if (!hit)
         $display("FAIL abort_reach: got no write at addr 5 within 30 cycles, required one");
      else
         n_pass++;
      #2 rst_n = 1'b0;
      #1;
      n_checks++;
      if (bus.we !== 1'b0 || bus.busy !== 1'b0)
         $display("FAIL abort_async: got we=%b busy=%b during reset, required 0 0", bus.we, bus.busy);
      else
         n_pass++;
      repeat (3) cyc();
      rst_n = 1'b1;
      repeat (40) cyc();
      n_checks++;
      if (n_writes - w0 !== 6 || exp_q.size() !== 0)
         $display("FAIL abort_no_resume: got %0d writes, %0d unserved, required 6 and 0", n_writes - w0, exp_q.size());
      else
         n_pass++;
   endtask

   initial begin
      test_reset();
      test_write_a();
      test_write_b();
      test_clear();
      test_pending();
      test_simultaneous();
      test_reset_mid_clear();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/ram_write_sequencer.md
Name: ram_write_sequencer

Overview:
- Owns the single write port of the demo RAM and sequences all writes into it.
- Three requesters share the port:
  - button write A;
  - button write B;
  - a full-memory clear sweep.
- Synchronizes the raw push-buttons, detects presses, arbitrates, and drives registered we/addr/wdata for one write per cycle.
- Sits between the board button pins and the RAM write port; status outputs feed LEDs/7-seg.

Parameters:
- ADDR_W, 8, RAM address width.
- DATA_W, 8, RAM data width.
- DEPTH, 256, words swept by clear (addresses 0..DEPTH-1); must be ≤ 2**ADDR_W.
- SYNC_STAGES, 2, flip-flops in each button synchronizer (≥2).
- DEBOUNCE_CYCLES, 16, stable-level count used only when DEBOUNCE_EN is defined.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- btn  in  3  raw push-buttons, active-low (0 = pressed). btn[0]=write A, btn[1]=write B, btn[2]=clear.
- we  out  1  RAM write enable, registered.
- addr  out  ADDR_W  RAM write address, registered.
- wdata  out  DATA_W  RAM write data, registered.
- busy  out  1  high while in WRITE or CLEAR.
- done  out  1  one-cycle pulse after any completed operation.

Behaviour:
- Reset (rst_n=0, immediate, asynchronous):
  - we=0, addr=0, wdata=0, busy=0, done=0.
  - State=IDLE, pending=NONE.
  - Synchronizers preset to released level (1), so no press is detected on reset release.
  - Reset asserted mid-CLEAR aborts the sweep; no resume after release.
- Press detection: falling edge of the synchronized btn bit produces a one-cycle press pulse.
  - Holding a button gives exactly one pulse; release and re-press gives another.
- Fixed operations:
  - Write A: addr=6, wdata=9.
  - Write B: addr=0, wdata=8.
  - Clear: addr 0..DEPTH-1, wdata=0.
- Priority for simultaneous press pulses: clear > A > B. The losers in that cycle are dropped, not queued.
- States: IDLE, WRITE, CLEAR, DONE.
- IDLE:
  - If pending≠NONE, serve pending first and clear it. New presses in that same cycle are treated as if busy.
  - Else clear press → CLEAR with addr=0.
  - Else A or B press → WRITE, loading addr/wdata.
  - we=0.
- WRITE: we=1 for exactly one cycle → DONE.
- CLEAR:
  - we=1, wdata=0 every cycle; addr increments by 1 per cycle.
  - In the cycle addr=DEPTH-1, write then → DONE.
  - Exactly DEPTH consecutive we cycles.
- DONE: we=0, done=1 for one cycle → IDLE.
- Presses while busy or in DONE:
  - The first A/B press is captured in a single-entry pending slot (A wins if A and B pulse together).
  - Further A/B presses are dropped while pending is occupied.
  - Clear presses while not in IDLE are ignored.
- Latency: from the first rising edge that samples a pressed level, we is high after SYNC_STAGES+2 edges (4 with defaults). The cycle sequence is sync, edge detect, IDLE decision, WRITE.
- addr and wdata hold their last values when we=0.

Optional Feature:
- DEBOUNCE_EN
  - Defined: each synchronized button must hold a new level for DEBOUNCE_CYCLES consecutive cycles before the filtered level changes. Edge detection uses the filtered level, so latency grows by DEBOUNCE_CYCLES. Glitches shorter than DEBOUNCE_CYCLES produce no press.
  - Undefined: edge detection runs directly on the synchronizer output; no counter logic is present.

Decomposition:
- Package ram_seq_pkg:
  - state enum {IDLE, WRITE, CLEAR, DONE};
  - pending enum {NONE, PEND_A, PEND_B};
  - button index constants BTN_A=0, BTN_B=1, BTN_CLR=2;
  - ADDR_A=6, DATA_A=9, ADDR_B=0, DATA_B=8.
- Sub-module btn_press_detect: synchronizer, optional debounce, falling-edge pulse for one button. Instantiated three times.

Test Plan:
- Reset: hold rst_n=0 with btn=3'b111, release → all outputs 0, no we for 20 cycles.
- Write A: drive btn=3'b110 for 10 cycles → exactly one we pulse, 4 edges after first sample, with addr=6, wdata=9; done pulses the next cycle.
- Write B: drive btn=3'b101 → one write with addr=0, wdata=8. Hold the button 50 cycles → still only one write.
- Clear with DEPTH=16: press btn[2] → 16 consecutive we cycles, addr 0..15, wdata=0, busy high throughout, then a done pulse.
- Press A during clear, then press B during clear → after clear completes, exactly one extra write (addr=6, wdata=9); B is dropped.
- A and clear pressed in the same cycle → clear runs; A produces no write. Assert rst_n=0 at addr=5 → we=0 immediately, and no writes after reset release.
